// File: rtl/mem_model_pkg.sv
// Shared constants and state encoding for the burst memory responder.
package mem_model_pkg;
    localparam int BURST_BEATS = 4;
    localparam int LINE_BYTES  = 32;
    localparam int BEAT_W      = 64;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} burst_state_t;
endpackage

// File: rtl/burst_mem_array.sv
// Beat-wide backing store: one synchronous read port, one write port, no reset.
module burst_mem_array
    import mem_model_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [BEAT_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [BEAT_W-1:0] o_rdata
);
    logic [BEAT_W-1:0] r_mem [DEPTH];
    logic [BEAT_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;
endmodule

// File: rtl/burst_mem_responder.sv
// Responder side of the 4-beat x 64-bit burst memory interface with
// programmable access latency and a sticky protocol-error flag.
module burst_mem_responder
    import mem_model_pkg::*;
#(
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4,
    parameter int LAT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_addr,
    input  logic [BEAT_W-1:0] pmem_wdata,
    output logic              pmem_resp,
    output logic [BEAT_W-1:0] pmem_rdata,
    output logic              err_o
);
    localparam int LINE_W     = $clog2(DEPTH_LINES);
    localparam int BEAT_IDX_W = $clog2(BURST_BEATS);
    localparam int AW         = LINE_W + BEAT_IDX_W;
    localparam int TAG_W      = 32 - OFFSET_BITS;
    localparam logic [LAT_W-1:0]      LAT_INIT  = LAT_W'(LATENCY - 1);
    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BURST_BEATS - 1);

    burst_state_t          r_state, w_state_nxt;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic [BEAT_IDX_W-1:0] r_beat, w_beat_nxt;
    logic [TAG_W-1:0]      r_tag;
    logic                  r_wr, r_err, r_rd_seen;

    logic                  w_req, w_wr_req, w_accept, w_busy;
    logic                  w_acc_err, w_proto_err, w_nxt_wr, w_we, w_re;
    logic [LINE_W-1:0]     w_line_nxt;
    logic [AW-1:0]         w_waddr, w_raddr;
    logic [BEAT_W-1:0]     w_q;

    assign w_req    = pmem_read | pmem_write;
    assign w_wr_req = pmem_write & ~pmem_read;
    // The last-beat edge cannot accept (state is BURST); the DONE exit edge is
    // the earliest point a held request is taken again.
    assign w_accept = w_req && (r_state == IDLE || r_state == DONE);
    assign w_busy   = (r_state == WAIT) || (r_state == BURST);

    assign w_acc_err   = (pmem_read & pmem_write) | (pmem_addr[OFFSET_BITS-1:0] != '0);
    assign w_proto_err = ~w_req | (w_wr_req != r_wr) | (pmem_addr[31:OFFSET_BITS] != r_tag);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_req) w_state_nxt = (LATENCY == 1) ? BURST : WAIT;
                else       w_state_nxt = IDLE;
            end
            WAIT:    if (r_lat_cnt == LAT_W'(1)) w_state_nxt = BURST;
            BURST:   if (r_beat == LAST_BEAT)    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat_cnt <= '0;
            r_beat    <= '0;
            r_tag     <= '0;
            r_wr      <= 1'b0;
            r_err     <= 1'b0;
            r_rd_seen <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tag     <= pmem_addr[31:OFFSET_BITS];
                r_wr      <= w_wr_req;
                r_lat_cnt <= LAT_INIT;
                r_beat    <= '0;
                if (w_acc_err) r_err <= 1'b1;
            end
            if (r_state == WAIT)  r_lat_cnt <= r_lat_cnt - LAT_W'(1);
            if (r_state == BURST) r_beat    <= r_beat + BEAT_IDX_W'(1);
            if (w_busy && w_proto_err) r_err <= 1'b1;
            if (w_re) r_rd_seen <= 1'b1;
        end
    end

    // Read data is fetched on the edge entering each beat so it is
    // valid for the whole resp cycle.
    assign w_nxt_wr   = w_accept ? w_wr_req : r_wr;
    assign w_line_nxt = w_accept ? pmem_addr[OFFSET_BITS +: LINE_W] : r_tag[LINE_W-1:0];
    assign w_beat_nxt = (r_state == BURST) ? r_beat + BEAT_IDX_W'(1) : '0;
    assign w_re       = !rst && (w_state_nxt == BURST) && !w_nxt_wr;
    assign w_raddr    = {w_line_nxt, w_beat_nxt};
    assign w_we       = !rst && (r_state == BURST) && r_wr;
    assign w_waddr    = {r_tag[LINE_W-1:0], r_beat};

    burst_mem_array #(.DEPTH(DEPTH_LINES * BURST_BEATS), .AW(AW)) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (pmem_wdata),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_q)
    );

    // Storage has no reset, so rdata reads zero until the first fetch.
    always_comb begin
        pmem_resp  = (r_state == BURST);
        pmem_rdata = r_rd_seen ? w_q : '0;
        err_o      = r_err;
    end
endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder (LATENCY=4 and LATENCY=1 builds).
module tb_burst_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr, rd1, wr1;
    logic [31:0] addr, addr1;
    logic [63:0] wdata, wdata1, rdata, rdata1;
    logic        resp, resp1, err, err1;

    int          checks = 0;
    int          failures = 0;
    int          n;
    logic [63:0] cap [4];

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] X0 = 64'h5A5A_0000_0000_0010;
    localparam logic [63:0] X1 = 64'h5A5A_0000_0000_0011;
    localparam logic [63:0] X2 = 64'h5A5A_0000_0000_0012;
    localparam logic [63:0] X3 = 64'h5A5A_0000_0000_0013;
    localparam logic [63:0] WA = 64'hAAAA_0000_0000_000A;
    localparam logic [63:0] WB = 64'hBBBB_0000_0000_000B;
    localparam logic [63:0] WC = 64'hCCCC_0000_0000_000C;
    localparam logic [63:0] WD = 64'hDDDD_0000_0000_000D;

    always #5 clk = ~clk;

    burst_mem_responder #(.DEPTH_LINES(256), .LATENCY(4), .LAT_W(8)) dut (
        .clk(clk), .rst(rst), .pmem_read(rd), .pmem_write(wr), .pmem_addr(addr),
        .pmem_wdata(wdata), .pmem_resp(resp), .pmem_rdata(rdata), .err_o(err)
    );

    burst_mem_responder #(.DEPTH_LINES(256), .LATENCY(1), .LAT_W(8)) dut1 (
        .clk(clk), .rst(rst), .pmem_read(rd1), .pmem_write(wr1), .pmem_addr(addr1),
        .pmem_wdata(wdata1), .pmem_resp(resp1), .pmem_rdata(rdata1), .err_o(err1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Edges until resp rises, bounded; an expired bound shows up as a wrong count.
    task automatic wait_resp(output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (!resp && k < 20);
    endtask

    task automatic beats(input string tag, input logic [63:0] w0, w1, w2, w3);
        logic [63:0] w [4];
        w = '{w0, w1, w2, w3};
        for (int b = 0; b < 4; b++) begin
            chk({tag, "_resp"}, 64'(resp), 64'd1);
            cap[b] = rdata;
            wdata  = w[b];
            tick();
        end
    endtask

    task automatic burst(input string tag, input logic r, input logic w_, input logic [31:0] a,
                         input logic [63:0] w0, w1, w2, w3);
        rd = r; wr = w_; addr = a; wdata = w0;
        wait_resp(n);
        chk({tag, "_lat"}, 64'(n), 64'd4);
        beats(tag, w0, w1, w2, w3);
        chk({tag, "_done"}, 64'(resp), 64'd0);
        rd = 1'b0; wr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd = 0; wr = 0; addr = 0; wdata = 0;
        rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
        repeat (3) tick();
        chk("rst_resp", 64'(resp), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_resp1", 64'(resp1), 64'd0);
        rst = 1'b0;
        tick();

        // write then read line 0x40
        burst("wr40", 1'b0, 1'b1, 32'h40, B1, B2, B3, B4);
        tick();
        burst("rd40", 1'b1, 1'b0, 32'h40, 0, 0, 0, 0);
        chk("rd40_b0", cap[0], B1);
        chk("rd40_b1", cap[1], B2);
        chk("rd40_b2", cap[2], B3);
        chk("rd40_b3", cap[3], B4);
        chk("rd40_err", 64'(err), 64'd0);
        chk("rd40_hold", rdata, B4);
        tick();

        // back-to-back: request held through DONE
        rd = 1'b1; addr = 32'h40;
        wait_resp(n);
        chk("b2b_lat", 64'(n), 64'd4);
        beats("b2b1", 0, 0, 0, 0);
        chk("b2b_gap", 64'(resp), 64'd0);
        wait_resp(n);
        chk("b2b_spacing", 64'(n), 64'd4);
        beats("b2b2", 0, 0, 0, 0);
        chk("b2b2_b0", cap[0], B1);
        chk("b2b2_b3", cap[3], B4);
        rd = 1'b0;
        n = 0;
        repeat (12) begin
            tick();
            if (resp) n++;
        end
        chk("b2b_extra", 64'(n), 64'd0);

        // aliasing: line index 0x100 wraps to 0 with 256 lines
        burst("wr2000", 1'b0, 1'b1, 32'h2000, 64'hDEAD_BEEF_0000_0001, 2, 3, 4);
        tick();
        burst("rd0000", 1'b1, 1'b0, 32'h0, 0, 0, 0, 0);
        chk("alias_b0", cap[0], 64'hDEAD_BEEF_0000_0001);
        chk("alias_b3", cap[3], 64'd4);
        tick();

        // reset in the middle of a write to line 0x80
        burst("wr80x", 1'b0, 1'b1, 32'h80, X0, X1, X2, X3);
        tick();
        wr = 1'b1; addr = 32'h80; wdata = WA;
        wait_resp(n);
        chk("rstw_lat", 64'(n), 64'd4);
        chk("rstw_b0", 64'(resp), 64'd1);
        wdata = WA; tick();
        chk("rstw_b1", 64'(resp), 64'd1);
        wdata = WB; tick();
        rst = 1'b1; wdata = WC; tick();
        chk("rstw_resp_low", 64'(resp), 64'd0);
        rst = 1'b0; wr = 1'b0; wdata = WD;
        chk("rstw_err", 64'(err), 64'd0);
        tick();
        burst("rd80", 1'b1, 1'b0, 32'h80, 0, 0, 0, 0);
        chk("rd80_b0", cap[0], WA);
        chk("rd80_b1", cap[1], WB);
        chk("rd80_b2", cap[2], X2);
        chk("rd80_b3", cap[3], X3);
        chk("rd80_err", 64'(err), 64'd0);
        tick();

        // read+write together at a misaligned address
        burst("both44", 1'b1, 1'b1, 32'h44, 0, 0, 0, 0);
        chk("both_b0", cap[0], B1);
        chk("both_b3", cap[3], B4);
        chk("both_err", 64'(err), 64'd1);
        repeat (5) tick();
        chk("both_err_sticky", 64'(err), 64'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("err_cleared", 64'(err), 64'd0);
        chk("rdata_cleared", rdata, 64'd0);

        // LATENCY=1 build: write then read line 0x20
        wr1 = 1'b1; addr1 = 32'h20; wdata1 = B3;
        n = 0;
        do begin tick(); n++; end while (!resp1 && n < 20);
        chk("l1_wr_lat", 64'(n), 64'd1);
        for (int b = 0; b < 4; b++) begin
            chk("l1_wr_resp", 64'(resp1), 64'd1);
            wdata1 = (b == 0) ? B3 : (b == 1) ? B4 : (b == 2) ? WA : WB;
            tick();
        end
        chk("l1_wr_done", 64'(resp1), 64'd0);
        wr1 = 1'b0;
        tick();
        rd1 = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!resp1 && n < 20);
        chk("l1_rd_lat", 64'(n), 64'd1);
        for (int b = 0; b < 4; b++) begin
            chk("l1_rd_resp", 64'(resp1), 64'd1);
            cap[b] = rdata1;
            tick();
        end
        rd1 = 1'b0;
        chk("l1_rd_done", 64'(resp1), 64'd0);
        chk("l1_b0", cap[0], B3);
        chk("l1_b1", cap[1], B4);
        chk("l1_b2", cap[2], WA);
        chk("l1_b3", cap[3], WB);
        chk("l1_err", 64'(err1), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
